// File: rtl/pong_pkg.sv
// Shared Pong definitions: match FSM states, screen geometry, speed-level
// type and small helpers used by the match sequencer and the datapath.
package pong_pkg;

    // Match sequencer states; encodings are visible on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_RALLY     = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } pong_state_t;

    // VGA visible-window boundaries (pixel clock counts / line counts).
    localparam int HBP = 144;
    localparam int HFP = 784;
    localparam int VBP = 31;
    localparam int VFP = 511;

    // Ball rest position while recentred.
    localparam int CENTER_X = HBP + 320;
    localparam int CENTER_Y = VBP + 240;

    // Counter and score widths.
    localparam int STEP_W  = 18;
    localparam int FRAME_W = 7;
    localparam int SCORE_W = 4;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd9;

    // Ball speed level: 0 slowest .. 2 fastest.
    typedef logic [1:0] speed_level_t;

    // Map the right-hand score onto a speed level.
    function automatic speed_level_t level_for_score(
        input logic [SCORE_W-1:0] score,
        input logic [SCORE_W-1:0] lvl1,
        input logic [SCORE_W-1:0] lvl2
    );
        speed_level_t lvl;
        if (score >= lvl2) begin
            lvl = 2'd2;
        end else if (score >= lvl1) begin
            lvl = 2'd1;
        end else begin
            lvl = 2'd0;
        end
        return lvl;
    endfunction

    // Increment a score, holding at the display maximum.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        logic [SCORE_W-1:0] r;
        if (s >= SCORE_MAX) begin
            r = SCORE_MAX;
        end else begin
            r = s + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pong_step_div.sv
// Programmable enable divider. While en is high the counter runs and a
// registered one-cycle tick is produced each time the count reaches div-1,
// after which the count wraps to 0. Dropping en clears the count, so the
// first tick after en rises comes div cycles later. The wrap test uses >=
// so switching to a shorter divisor mid-count cannot be skipped past.
module pong_step_div
    import pong_pkg::*;
#(
    parameter int W = STEP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] div,
    output logic         tick
);

    logic [W-1:0] cnt;
    logic [W-1:0] last;

    // Terminal count for the selected divisor.
    assign last = div - W'(1);

    // Count while enabled, wrap and emit a tick at the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (!en) begin
                cnt <= '0;
            end else if (cnt >= last) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: owns scores, serve and point pauses, win detection
// and ball speed level, and issues one-cycle ball_step enables to the
// ball/paddle datapath.
//
// Event interface: frame_tick, start, miss_l and miss_r are single-cycle
// pulses sampled on dclk; a pulse is consumed in the cycle it is high and
// only in the states that accept it, otherwise it is dropped. ball_step is
// a single-cycle pulse produced only while the ball is in play.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 9,
    parameter int LVL1_SCORE   = 3,
    parameter int LVL2_SCORE   = 6,
    parameter int STEP_DIV_L0  = 250000,
    parameter int STEP_DIV_L1  = 166667,
    parameter int STEP_DIV_L2  = 125000,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic               dclk,
    input  logic               clr_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               miss_l,
    input  logic               miss_r,
    output logic               ball_step,
    output logic               ball_recenter,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output speed_level_t       speed_level,
    output logic [2:0]         state_o,
    output logic               game_over,
    output logic               winner
);

    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] LVL1_VAL = SCORE_W'(LVL1_SCORE);
    localparam logic [SCORE_W-1:0] LVL2_VAL = SCORE_W'(LVL2_SCORE);

    localparam logic [STEP_W-1:0] DIV_L0 = STEP_W'(STEP_DIV_L0);
    localparam logic [STEP_W-1:0] DIV_L1 = STEP_W'(STEP_DIV_L1);
    localparam logic [STEP_W-1:0] DIV_L2 = STEP_W'(STEP_DIV_L2);

    localparam logic [FRAME_W-1:0] SERVE_LAST = FRAME_W'(SERVE_FRAMES - 1);
    localparam logic [FRAME_W-1:0] POINT_LAST = FRAME_W'(POINT_FRAMES - 1);

    pong_state_t        state;
    pong_state_t        state_next;
    logic [FRAME_W-1:0] frame_cnt;
    logic [STEP_W-1:0]  step_div;
    logic               step_en;
    logic               in_rally;
    logic               in_pause;
    logic               restart;
    logic               miss_any;
    logic               score_l_pt;
    logic               score_r_pt;
    logic               win_reached;
    logic               serve_done;
    logic               point_done;

    // Decode accepted events and counter terminal conditions.
    always_comb begin
        in_rally    = (state == ST_RALLY);
        in_pause    = (state == ST_SERVE) || (state == ST_POINT);
        restart     = start && ((state == ST_IDLE) || (state == ST_GAME_OVER));
        miss_any    = in_rally && (miss_l || miss_r);
        score_l_pt  = in_rally && miss_r && !miss_l;
        score_r_pt  = in_rally && miss_l && !miss_r;
        win_reached = (score_l == WIN_VAL) || (score_r == WIN_VAL);
        serve_done  = frame_tick && (frame_cnt == SERVE_LAST);
        point_done  = frame_tick && (frame_cnt == POINT_LAST);
    end

    // State register.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (serve_done) begin
                    state_next = ST_RALLY;
                end
            end
            ST_RALLY: begin
                if (miss_l || miss_r) begin
                    state_next = ST_POINT;
                end
            end
            ST_POINT: begin
                if (point_done) begin
                    state_next = win_reached ? ST_GAME_OVER : ST_SERVE;
                end
            end
            ST_GAME_OVER: begin
                if (start) begin
                    state_next = ST_SERVE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        ball_recenter = (state != ST_RALLY);
        game_over     = (state == ST_GAME_OVER);
        state_o       = state;
    end

    // Frame counter: counts ticks in SERVE/POINT, cleared on every state change.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            frame_cnt <= '0;
        end else if ((state_next != state) || !in_pause) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end

    // Scores and serve direction: cleared on a new match, bumped on a point.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            score_l   <= '0;
            score_r   <= '0;
            serve_dir <= 1'b0;
        end else if (restart) begin
            score_l   <= '0;
            score_r   <= '0;
            serve_dir <= 1'b0;
        end else if (score_l_pt) begin
            score_l   <= score_inc(score_l);
            serve_dir <= 1'b0;
        end else if (score_r_pt) begin
            score_r   <= score_inc(score_r);
            serve_dir <= 1'b1;
        end
    end

    // Speed level follows score_r one cycle later; reset to 0 on a new match.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            speed_level <= 2'd0;
        end else if (restart) begin
            speed_level <= 2'd0;
        end else begin
            speed_level <= level_for_score(score_r, LVL1_VAL, LVL2_VAL);
        end
    end

    // Winner is latched on the way into GAME_OVER and held until the next one.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            winner <= 1'b0;
        end else if ((state == ST_POINT) && point_done && win_reached) begin
            winner <= (score_r == WIN_VAL);
        end
    end

    // Divisor for the current speed level.
    always_comb begin
        case (speed_level)
            2'd1:    step_div = DIV_L1;
            2'd2:    step_div = DIV_L2;
            default: step_div = DIV_L0;
        endcase
    end

    // The divider runs only while the ball is in play and no miss is landing.
    assign step_en = in_rally && !miss_any;

    pong_step_div #(
        .W (STEP_W)
    ) u_step_div (
        .clk   (dclk),
        .rst_n (clr_n),
        .en    (step_en),
        .div   (step_div),
        .tick  (ball_step)
    );

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed match sequence; expected state-change
// snapshots and ball_step intervals are queued by the stimulus and popped by
// a monitor whenever the DUT changes state or pulses ball_step.
module tb_pong_match_ctrl;

  localparam int WIN = 7;
  localparam int L1  = 3;
  localparam int L2  = 6;
  localparam int D0  = 10;
  localparam int D1  = 7;
  localparam int D2  = 5;
  localparam int SF  = 4;
  localparam int PF  = 3;

  // clock / reset
  logic dclk = 1'b0;
  logic clr_n = 1'b1;
  logic frame_tick = 1'b0;
  logic start = 1'b0;
  logic miss_l = 1'b0;
  logic miss_r = 1'b0;

  logic       ball_step;
  logic       ball_recenter;
  logic       serve_dir;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] speed_level;
  logic [2:0] state_o;
  logic       game_over;
  logic       winner;

  always #5 dclk = ~dclk;

  pong_match_ctrl #(
    .WIN_SCORE    (WIN),
    .LVL1_SCORE   (L1),
    .LVL2_SCORE   (L2),
    .STEP_DIV_L0  (D0),
    .STEP_DIV_L1  (D1),
    .STEP_DIV_L2  (D2),
    .SERVE_FRAMES (SF),
    .POINT_FRAMES (PF)
  ) dut (
    .dclk          (dclk),
    .clr_n         (clr_n),
    .frame_tick    (frame_tick),
    .start         (start),
    .miss_l        (miss_l),
    .miss_r        (miss_r),
    .ball_step     (ball_step),
    .ball_recenter (ball_recenter),
    .serve_dir     (serve_dir),
    .score_l       (score_l),
    .score_r       (score_r),
    .speed_level   (speed_level),
    .state_o       (state_o),
    .game_over     (game_over),
    .winner        (winner)
  );

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [16:0] exp_q[$];
  int step_q[$];
  int steps_seen = 0;
  int since_step = 0;
  logic [2:0] prev_state = 3'd0;

  // match model
  int m_sl, m_sr, m_sd, m_lvl;

  function automatic logic [16:0] snap(int st, int sl, int sr, int sd, int lvl,
                                       int go, int win, int rc);
    logic [16:0] v;
    v = {3'(st), 4'(sl), 4'(sr), 1'(sd), 2'(lvl), 1'(go), 1'(win), 1'(rc)};
    return v;
  endfunction

  function automatic int lvl_of(int sr);
    if (sr >= L2) return 2;
    if (sr >= L1) return 1;
    return 0;
  endfunction

  function automatic int period_of(int lvl);
    if (lvl == 2) return D2;
    if (lvl == 1) return D1;
    return D0;
  endfunction

  task automatic check_snap(input string name, input logic [16:0] exp);
    logic [16:0] act;
    logic [16:0] mask;
    act  = {state_o, score_l, score_r, serve_dir, speed_level, game_over, winner, ball_recenter};
    mask = exp[2] ? 17'h1ffff : 17'h1fffd;
    total++;
    if ((act & mask) !== (exp & mask)) begin
      bad++;
      $display("FAIL %s: got st=%0d sl=%0d sr=%0d dir=%0d lvl=%0d go=%0d win=%0d rc=%0d want st=%0d sl=%0d sr=%0d dir=%0d lvl=%0d go=%0d win=%0d rc=%0d",
               name, act[16:14], act[13:10], act[9:6], act[5], act[4:3], act[2], act[1], act[0],
               exp[16:14], exp[13:10], exp[9:6], exp[5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // monitor: pop on every state change and every ball_step
  always @(negedge dclk) begin
    if (state_o !== prev_state) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_state_change: got %0d from %0d want no change", state_o, prev_state);
      end else begin
        check_snap("state_change", exp_q.pop_front());
      end
      since_step = 0;
    end else begin
      since_step++;
    end
    prev_state = state_o;
    if (ball_step === 1'b1) begin
      steps_seen++;
      total++;
      if (state_o != 3'd2 || step_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_step: got step in state %0d want none", state_o);
      end else begin
        int e;
        e = step_q.pop_front();
        if (since_step != e) begin
          bad++;
          $display("FAIL step_period: got %0d cycles want %0d", since_step, e);
        end
      end
      since_step = 0;
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge dclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(2);
    end
  endtask

  task automatic wait_steps(input int target);
    int guard;
    guard = 0;
    while (steps_seen < target && guard < 400) begin
      cyc(1);
      guard++;
    end
    total++;
    if (steps_seen < target) begin
      bad++;
      $display("FAIL step_timeout: got %0d steps want %0d", steps_seen, target);
    end
  endtask

  // kind: 0 = miss_r, 1 = miss_l, 2 = both. Starts in SERVE, ends in SERVE/GAME_OVER.
  task automatic play_point(input int kind, input int n_steps, input bit poke_start);
    int base;
    int old_lvl;
    exp_q.push_back(snap(2, m_sl, m_sr, m_sd, m_lvl, 0, 0, 0));
    frames(SF);
    base = steps_seen;
    for (int i = 0; i < n_steps; i++) step_q.push_back(period_of(m_lvl));
    wait_steps(base + n_steps);
    if (poke_start) pulse_start();
    if (kind == 0) begin m_sl++; m_sd = 0; end
    if (kind == 1) begin m_sr++; m_sd = 1; end
    old_lvl = m_lvl;
    exp_q.push_back(snap(3, m_sl, m_sr, m_sd, old_lvl, 0, 0, 1));
    miss_r = (kind != 1);
    miss_l = (kind != 0);
    cyc(1);
    miss_r = 1'b0;
    miss_l = 1'b0;
    m_lvl = lvl_of(m_sr);
    if (m_sl == WIN || m_sr == WIN)
      exp_q.push_back(snap(4, m_sl, m_sr, m_sd, m_lvl, 1, (m_sr == WIN) ? 1 : 0, 1));
    else
      exp_q.push_back(snap(1, m_sl, m_sr, m_sd, m_lvl, 0, 0, 1));
    frames(PF);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000ns");
    $fatal(1, "watchdog");
  end

  // main stimulus
  initial begin
    m_sl = 0; m_sr = 0; m_sd = 0; m_lvl = 0;
    #1 clr_n = 1'b0;
    cyc(3);
    check_snap("reset", snap(0, 0, 0, 0, 0, 0, 0, 1));
    total++;
    if (ball_step !== 1'b0) begin bad++; $display("FAIL reset_step: got %0b want 0", ball_step); end
    clr_n = 1'b1;
    cyc(1);

    // ignored in IDLE
    miss_r = 1'b1; cyc(1); miss_r = 1'b0;
    frames(2);

    exp_q.push_back(snap(1, 0, 0, 0, 0, 0, 0, 1));
    pulse_start();
    // ignored in SERVE
    miss_l = 1'b1; cyc(1); miss_l = 1'b0;
    pulse_start();

    play_point(0, 3, 1'b1);   // left scores, start poked mid-rally
    play_point(1, 2, 1'b0);   // sr=1
    play_point(1, 2, 1'b0);   // sr=2
    play_point(2, 1, 1'b0);   // double miss, no score
    play_point(1, 1, 1'b0);   // sr=3 -> level 1
    play_point(1, 3, 1'b0);   // sr=4, period D1
    play_point(1, 1, 1'b0);   // sr=5
    play_point(1, 1, 1'b0);   // sr=6 -> level 2
    play_point(1, 3, 1'b0);   // sr=7, period D2 -> game over

    // ignored in GAME_OVER
    miss_l = 1'b1; cyc(1); miss_l = 1'b0;
    miss_r = 1'b1; cyc(1); miss_r = 1'b0;
    frames(2);
    check_snap("game_over_hold", snap(4, 1, 7, 1, 2, 1, 1, 1));

    // restart
    m_sl = 0; m_sr = 0; m_sd = 0; m_lvl = 0;
    exp_q.push_back(snap(1, 0, 0, 0, 0, 0, 0, 1));
    pulse_start();
    exp_q.push_back(snap(2, 0, 0, 0, 0, 0, 0, 0));
    frames(SF);
    cyc(5);

    // reset mid-rally
    exp_q.push_back(snap(0, 0, 0, 0, 0, 0, 0, 1));
    clr_n = 1'b0;
    #1;
    total++;
    if (ball_step !== 1'b0 || ball_recenter !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: got step=%0b rc=%0b want step=0 rc=1", ball_step, ball_recenter);
    end
    cyc(2);
    clr_n = 1'b1;
    cyc(10);
    frames(5);
    check_snap("idle_after_reset", snap(0, 0, 0, 0, 0, 0, 0, 1));

    exp_q.push_back(snap(1, 0, 0, 0, 0, 0, 0, 1));
    pulse_start();
    exp_q.push_back(snap(2, 0, 0, 0, 0, 0, 0, 0));
    frames(SF);
    step_q.push_back(D0);
    wait_steps(steps_seen + 1);
    cyc(2);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL exp_q_drain: got %0d left want 0", exp_q.size());
    end
    total++;
    if (step_q.size() != 0) begin
      bad++;
      $display("FAIL step_q_drain: got %0d left want 0", step_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
